// File: rtl/accelerator_read_weighting_multimode.sv
// Read-head weighting stage with configurable mode count.
// For each head i and location j it computes w(i,j) = sum_p pi(i)[p] * v_p(i,j)
// in signed fixed point, then saturates to DATA_SIZE and keeps a sticky
// OVERFLOW flag. Operands arrive on two valid/ready streams. Per head the
// MODES pi coefficients come first, then N groups of MODES vector beats.
module accelerator_read_weighting_multimode #(
    parameter int DATA_SIZE     = 32,
    parameter int CONTROL_SIZE  = 32,
    parameter int FRACTION_SIZE = 16,
    parameter int MODES         = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] SIZE_R_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_N_IN,
    input  logic                    PI_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    PI_IN,
    output logic                    PI_IN_READY,
    input  logic                    VECTOR_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    VECTOR_IN,
    output logic                    VECTOR_IN_READY,
    output logic [DATA_SIZE-1:0]    W_OUT,
    output logic                    W_OUT_ENABLE,
    output logic                    W_OUT_I_ENABLE,
    output logic                    W_OUT_J_ENABLE,
    output logic                    OVERFLOW
);
    localparam int PBW = (MODES > 1) ? $clog2(MODES) : 1;
    // Accumulator is wide enough that MODES-1 partial sums never wrap.
    localparam int AW  = DATA_SIZE + FRACTION_SIZE + $clog2(MODES) + 1;
    localparam int PW  = 2 * DATA_SIZE;
    // Final-sum width: covers both the accumulator and the full product.
    localparam int SW  = ((AW > PW) ? AW : PW) + 1;
    localparam logic [PBW-1:0] P_LAST = PBW'(MODES - 1);

    typedef enum logic [1:0] {IDLE, PI_LOAD, ACCUMULATE, FINISH} state_t;
    state_t state, state_nxt;

    logic [CONTROL_SIZE-1:0] r_reg, n_reg, i_cnt, j_cnt;
    logic [PBW-1:0]          p_cnt;
    logic [DATA_SIZE-1:0]    pi_reg [MODES];
    logic signed [AW-1:0]    acc;

    logic                    pi_acc, vec_acc, p_last, j_last, i_last, size_zero;
    logic signed [PW-1:0]    prod_full;
    logic signed [SW-1:0]    prod_ext, sum_ext;
    logic                    sat_hi, sat_lo;
    logic [DATA_SIZE-1:0]    w_sat;

    assign pi_acc    = PI_IN_ENABLE && PI_IN_READY;
    assign vec_acc   = VECTOR_IN_ENABLE && VECTOR_IN_READY;
    assign p_last    = (p_cnt == P_LAST);
    assign j_last    = (j_cnt == n_reg - CONTROL_SIZE'(1));
    assign i_last    = (i_cnt == r_reg - CONTROL_SIZE'(1));
    assign size_zero = (SIZE_R_IN == '0) || (SIZE_N_IN == '0);

    // Product of the selected mode coefficient and the incoming vector
    // element. The arithmetic shift rounds toward minus infinity.
    assign prod_full = PW'($signed(pi_reg[p_cnt])) * PW'($signed(VECTOR_IN));
    assign prod_ext  = SW'(prod_full >>> FRACTION_SIZE);
    assign sum_ext   = SW'(acc) + prod_ext;

    // Saturate when the bits above the DATA_SIZE sign bit disagree with the sign.
    assign sat_hi = !sum_ext[SW-1] && (|sum_ext[SW-2:DATA_SIZE-1]);
    assign sat_lo =  sum_ext[SW-1] && !(&sum_ext[SW-2:DATA_SIZE-1]);
    assign w_sat  = sat_hi ? {1'b0, {(DATA_SIZE-1){1'b1}}} :
                    sat_lo ? {1'b1, {(DATA_SIZE-1){1'b0}}} :
                             sum_ext[DATA_SIZE-1:0];

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (START) state_nxt = size_zero ? FINISH : PI_LOAD;
            PI_LOAD:    if (pi_acc && p_last) state_nxt = ACCUMULATE;
            ACCUMULATE: if (vec_acc && p_last && j_last)
                            state_nxt = i_last ? FINISH : PI_LOAD;
            FINISH:     state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Stream readies depend on the state only, so they can never overlap
    always_comb begin
        PI_IN_READY     = (state == PI_LOAD);
        VECTOR_IN_READY = (state == ACCUMULATE);
    end

    // Counters, operand capture, accumulation and the registered result outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_reg          <= '0;
            n_reg          <= '0;
            i_cnt          <= '0;
            j_cnt          <= '0;
            p_cnt          <= '0;
            acc            <= '0;
            for (int k = 0; k < MODES; k++) pi_reg[k] <= '0;
            READY          <= 1'b0;
            W_OUT          <= '0;
            W_OUT_ENABLE   <= 1'b0;
            W_OUT_I_ENABLE <= 1'b0;
            W_OUT_J_ENABLE <= 1'b0;
            OVERFLOW       <= 1'b0;
        end else begin
            READY          <= (state == FINISH);
            W_OUT_ENABLE   <= 1'b0;
            W_OUT_I_ENABLE <= 1'b0;
            W_OUT_J_ENABLE <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    r_reg    <= SIZE_R_IN;
                    n_reg    <= SIZE_N_IN;
                    i_cnt    <= '0;
                    j_cnt    <= '0;
                    p_cnt    <= '0;
                    OVERFLOW <= 1'b0;
                end
                PI_LOAD: if (pi_acc) begin
                    pi_reg[p_cnt] <= PI_IN;
                    if (p_last) begin
                        p_cnt <= '0;
                        j_cnt <= '0;
                        acc   <= '0;
                    end else begin
                        p_cnt <= p_cnt + PBW'(1);
                    end
                end
                ACCUMULATE: if (vec_acc) begin
                    if (!p_last) begin
                        acc   <= AW'(sum_ext);
                        p_cnt <= p_cnt + PBW'(1);
                    end else begin
                        W_OUT          <= w_sat;
                        W_OUT_ENABLE   <= 1'b1;
                        W_OUT_J_ENABLE <= 1'b1;
                        W_OUT_I_ENABLE <= j_last;
                        if (sat_hi || sat_lo) OVERFLOW <= 1'b1;
                        acc   <= '0;
                        p_cnt <= '0;
                        if (j_last) begin
                            j_cnt <= '0;
                            i_cnt <= i_cnt + CONTROL_SIZE'(1);
                        end else begin
                            j_cnt <= j_cnt + CONTROL_SIZE'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/accelerator_read_weighting_multimode.md
Name: accelerator_read_weighting_multimode

Overview:
- Parametrised successor of the DNC read-head weighting stage.
- Computes w(t;i,j) = sum over p=0..MODES-1 of pi(t;i)[p]·v_p(t;i,j) for R read heads and N memory locations.
- Signed fixed-point arithmetic with per-element saturation and a sticky overflow flag.
- Sits between the read-mode (pi) and forward/backward/content weighting producers and the read-vector stage; all operands are streamed with valid/ready handshakes.

Parameters:
- DATA_SIZE, 32: operand/result width, signed two's complement.
- CONTROL_SIZE, 32: width of size inputs and internal counters.
- FRACTION_SIZE, 16: fractional bits (Q format) of all operands and results.
- MODES, 3: number of read modes per head, 1..16.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  begin operation; sampled only in IDLE.
- READY  out  1  one-cycle pulse when the whole R×N result has been produced.
- SIZE_R_IN  in  CONTROL_SIZE  number of heads R; latched at START.
- SIZE_N_IN  in  CONTROL_SIZE  number of locations N; latched at START.
- PI_IN_ENABLE  in  1  PI_IN valid.
- PI_IN  in  DATA_SIZE  mode coefficient pi(i)[p], streamed p=0..MODES-1.
- PI_IN_READY  out  1  block accepts PI_IN.
- VECTOR_IN_ENABLE  in  1  VECTOR_IN valid.
- VECTOR_IN  in  DATA_SIZE  v_p(i,j); for each j, streamed p=0..MODES-1.
- VECTOR_IN_READY  out  1  block accepts VECTOR_IN.
- W_OUT  out  DATA_SIZE  result w(i,j).
- W_OUT_ENABLE  out  1  W_OUT valid, one-cycle pulse.
- W_OUT_I_ENABLE  out  1  asserted with W_OUT_ENABLE when j==N-1 (last element of head i).
- W_OUT_J_ENABLE  out  1  asserted with every W_OUT_ENABLE.
- OVERFLOW  out  1  sticky: saturation occurred since last START.

Behaviour:
- Reset (async, RST=1): state IDLE; counters cleared; READY, W_OUT, W_OUT_ENABLE, W_OUT_I_ENABLE, W_OUT_J_ENABLE, PI_IN_READY, VECTOR_IN_READY and OVERFLOW all 0; accumulator and pi registers cleared. Reset mid-operation abandons the operation with no READY pulse.
- Handshake: a beat is accepted on a rising edge only when enable and ready are both 1. Gaps in the enables stall the block with no loss of state. Enables in the wrong state are ignored.
- States:
  - IDLE: both readies 0. START=1 latches the sizes and clears OVERFLOW and the counters i, j, p. Next state is PI_LOAD, or FINISH if R==0 or N==0.
  - PI_LOAD: PI_IN_READY=1. Each accepted beat stores pi_reg[p] and increments p. On acceptance with p==MODES-1: p=0, j=0, accumulator=0, next state ACCUMULATE.
  - ACCUMULATE: VECTOR_IN_READY=1. Per accepted beat, prod = (pi_reg[p]·VECTOR_IN), a 2·DATA_SIZE signed product, arithmetic-shifted right by FRACTION_SIZE (floor rounding).
    - For p<MODES-1: acc += prod. acc is DATA_SIZE+FRACTION_SIZE+clog2(MODES)+1 bits, so it cannot wrap.
    - For p==MODES-1: sum = acc+prod, saturated to signed DATA_SIZE, is registered to W_OUT on the same edge. W_OUT_ENABLE=1 and W_OUT_J_ENABLE=1 for the following cycle; W_OUT_I_ENABLE=1 too if j==N-1. If saturation occurred, OVERFLOW<=1. Then acc=0, p=0, j++.
    - After j==N-1: i++, next state PI_LOAD, or FINISH if i==R-1.
  - FINISH: READY=1 for exactly one cycle, then IDLE. Latency: READY is high one cycle after the final W_OUT_ENABLE cycle; for R or N == 0, two cycles after START.
- W_OUT holds its last value between pulses.
- START outside IDLE is ignored.
- PI_IN_READY and VECTOR_IN_READY are never both 1.
- Saturation bounds: max 2^(DATA_SIZE-1)-1, min -2^(DATA_SIZE-1).

Test Plan (DATA_SIZE=32, FRACTION_SIZE=16, MODES=3):
- R=1, N=1, pi={0x4000,0x8000,0x4000}, v={0x10000,0x20000,0x40000} -> one W_OUT=0x00024000 with I/J enables high, OVERFLOW=0, READY one cycle later.
- R=2, N=3 with random enable gaps -> 6 outputs in order (i,j); W_OUT_I_ENABLE only on j=2; readies never overlap; results match the golden model.
- pi all 0x10000, v all 0x7FFF0000 -> W_OUT=0x7FFFFFFF, OVERFLOW=1. Next START clears it; a following in-range run leaves it 0.
- pi={0xFFFF0000,0,0}, v={0x8000,0x7FFF0000,0x1} -> W_OUT=0xFFFF8000, negative product with floor shift.
- SIZE_R_IN=0 or SIZE_N_IN=0 -> no W_OUT_ENABLE; READY pulses 2 cycles after START. START asserted while in ACCUMULATE has no effect.
- RST pulsed mid-ACCUMULATE -> all outputs 0 asynchronously; no READY. A fresh START then completes correctly.
